// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle RV32I core
module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [2:0] o_ALUControl,
    output logic [2:0] o_ImmSrc
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    state_t     state, next;
    logic [2:0] alu_dec;

    // state register; reset abandons any instruction in flight
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= FETCH;
        else       state <= next;

    // next-state sequencing, memory states hold until ready
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = i_mem_ready ? DECODE : FETCH;
            DECODE:   next = (i_opcode == OP_LW || i_opcode == OP_SW) ? MEMADR :
                             (i_opcode == OP_R)   ? EXECR  :
                             (i_opcode == OP_I)   ? EXECI  :
                             (i_opcode == OP_BR)  ? BRANCH :
                             (i_opcode == OP_JAL) ? JAL    :
                             (i_opcode == OP_LUI) ? LUI    : FETCH;
            MEMADR:   next = (i_opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next = i_mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = i_mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, LUI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    // ALU op from funct3; bit30 selects sub only for register-register ops
    always_comb
        alu_dec = (i_funct3 == 3'b010) ? 3'b101 :
                  (i_funct3 == 3'b110) ? 3'b011 :
                  (i_funct3 == 3'b111) ? 3'b010 :
                  (i_funct3 == 3'b000 && state == EXECR && i_funct7b5) ? 3'b001 : 3'b000;

    // immediate format follows the opcode regardless of state
    always_comb
        o_ImmSrc = (i_opcode == OP_SW)  ? 3'b001 :
                   (i_opcode == OP_BR)  ? 3'b010 :
                   (i_opcode == OP_JAL) ? 3'b011 :
                   (i_opcode == OP_LUI) ? 3'b100 : 3'b000;

    // per-state datapath controls; reset kills every write enable at once
    always_comb begin
        o_PCWrite    = 1'b0;
        o_AdrSrc     = 1'b0;
        o_MemWrite   = 1'b0;
        o_IRWrite    = 1'b0;
        o_RegWrite   = 1'b0;
        o_ResultSrc  = 2'b00;
        o_ALUSrcA    = 2'b00;
        o_ALUSrcB    = 2'b00;
        o_ALUControl = 3'b000;
        case (state)
            FETCH: begin
                o_ResultSrc = 2'b10;
                o_ALUSrcB   = 2'b10;
                o_IRWrite   = i_mem_ready;
                o_PCWrite   = i_mem_ready;
            end
            DECODE: begin
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b01;
            end
            MEMADR: begin
                o_ALUSrcA = 2'b10;
                o_ALUSrcB = 2'b01;
            end
            MEMREAD:  o_AdrSrc = 1'b1;
            MEMWB: begin
                o_ResultSrc = 2'b01;
                o_RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                o_AdrSrc   = 1'b1;
                o_MemWrite = 1'b1;
            end
            EXECR: begin
                o_ALUSrcA    = 2'b10;
                o_ALUControl = alu_dec;
            end
            EXECI: begin
                o_ALUSrcA    = 2'b10;
                o_ALUSrcB    = 2'b01;
                o_ALUControl = alu_dec;
            end
            ALUWB:    o_RegWrite = 1'b1;
            BRANCH: begin
                o_ALUSrcA    = 2'b10;
                o_ALUControl = 3'b001;
                o_PCWrite    = (i_funct3 == 3'b000 && i_zero) || (i_funct3 == 3'b001 && !i_zero);
            end
            JAL: begin
                o_ALUSrcA  = 2'b01;
                o_ALUSrcB  = 2'b10;
                o_PCWrite  = 1'b1;
                o_RegWrite = 1'b1;
            end
            LUI:      o_ALUSrcB = 2'b01;
            default: ;
        endcase
        if (i_rst) begin
            o_PCWrite  = 1'b0;
            o_MemWrite = 1'b0;
            o_IRWrite  = 1'b0;
            o_RegWrite = 1'b0;
        end
    end
endmodule
